// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves conditional branches, JAL and JALR in execute,
// checks the fetch-stage prediction and registers the result in a single
// valid/ready output stage. Keeps saturating retire/mispredict counters.
module branch_resolve_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_link,
    output logic             out_mispredict,
    output logic             out_illegal,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_mispredicts
);

    localparam logic [1:0] KindCond = 2'b00;
    localparam logic [1:0] KindJal  = 2'b01;
    localparam logic [1:0] KindJalr = 2'b10;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] taken_target;
    logic [XLEN-1:0] next_target;
    logic            cond_true;
    logic            funct3_bad;
    logic            taken;
    logic            illegal;
    logic            mispredict;
    logic            accept;
    logic            retire;

    assign pc_plus4  = in_pc + XLEN'(4);
    assign br_target = in_pc + in_imm;
    assign jalr_sum  = in_rs1 + in_imm;

    // No bubble when draining: a new request may enter as the held one leaves.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !kill;
    assign retire   = out_valid && out_ready && !kill;

    // Evaluate the branch condition selected by funct3.
    always_comb begin
        cond_true  = 1'b0;
        funct3_bad = 1'b0;
        case (in_funct3)
            3'b000:  cond_true = (in_rs1 == in_rs2);
            3'b001:  cond_true = (in_rs1 != in_rs2);
            3'b100:  cond_true = ($signed(in_rs1) < $signed(in_rs2));
            3'b101:  cond_true = ($signed(in_rs1) >= $signed(in_rs2));
            3'b110:  cond_true = (in_rs1 < in_rs2);
            3'b111:  cond_true = (in_rs1 >= in_rs2);
            default: funct3_bad = 1'b1;
        endcase
    end

    // Resolve direction, target and prediction check for the incoming request.
    always_comb begin
        taken        = 1'b0;
        illegal      = 1'b0;
        taken_target = br_target;
        case (in_kind)
            KindCond: begin
                taken   = cond_true;
                illegal = funct3_bad;
            end
            KindJal:  taken = 1'b1;
            KindJalr: begin
                taken        = 1'b1;
                taken_target = {jalr_sum[XLEN-1:1], 1'b0};
            end
            default:  illegal = 1'b1;
        endcase
        next_target = taken ? taken_target : pc_plus4;
        // Compare against the raw taken target; pc+4 is irrelevant when not taken.
        mispredict  = (taken != in_pred_taken) || (taken && (taken_target != in_pred_target));
    end

    // Output valid: kill and reset drop the held result; otherwise load or drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (kill) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Output data: only loads on accept, so held fields never change.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_taken      <= 1'b0;
            out_target     <= '0;
            out_link       <= '0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
        end else if (accept) begin
            out_taken      <= taken;
            out_target     <= next_target;
            out_link       <= pc_plus4;
            out_mispredict <= mispredict;
            out_illegal    <= illegal;
        end
    end

    // Saturating performance counters; clear wins over a same-cycle retire.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cnt_branches    <= '0;
            cnt_mispredicts <= '0;
        end else if (retire) begin
            if (cnt_branches != {CNT_W{1'b1}}) begin
                cnt_branches <= cnt_branches + CNT_W'(1);
            end
            if (out_mispredict && (cnt_mispredicts != {CNT_W{1'b1}})) begin
                cnt_mispredicts <= cnt_mispredicts + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed cases then random traffic
// with backpressure, kill, counter clear and occasional reset.
module tb_branch_resolve_unit;

    localparam int CW  = 3;
    localparam int SAT = (1 << CW) - 1;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] link;
        logic        mis;
        logic        ill;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_kind;
    logic [2:0]    in_funct3;
    logic [31:0]   in_rs1;
    logic [31:0]   in_rs2;
    logic [31:0]   in_pc;
    logic [31:0]   in_imm;
    logic          in_pred_taken;
    logic [31:0]   in_pred_target;
    logic          kill;
    logic          out_valid;
    logic          out_ready;
    logic          out_taken;
    logic [31:0]   out_target;
    logic [31:0]   out_link;
    logic          out_mispredict;
    logic          out_illegal;
    logic          cnt_clear;
    logic [CW-1:0] cnt_branches;
    logic [CW-1:0] cnt_mispredicts;

    exp_t exp_q[$];
    bit   m_valid = 1'b0;
    bit   m_next  = 1'b0;
    bit   mon_en  = 1'b0;
    int   m_br    = 0;
    int   m_mp    = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    branch_resolve_unit #(.XLEN(32), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
        .in_pred_target(in_pred_target), .kill(kill), .out_valid(out_valid),
        .out_ready(out_ready), .out_taken(out_taken), .out_target(out_target),
        .out_link(out_link), .out_mispredict(out_mispredict), .out_illegal(out_illegal),
        .cnt_clear(cnt_clear), .cnt_branches(cnt_branches), .cnt_mispredicts(cnt_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference behaviour written straight from the branch rules.
    function automatic exp_t ref_model(input logic [1:0] kind, input logic [2:0] f3,
                                       input logic [31:0] rs1, input logic [31:0] rs2,
                                       input logic [31:0] pc, input logic [31:0] imm,
                                       input logic pt, input logic [31:0] ptgt);
        exp_t e;
        logic [31:0] tgt;
        e.taken = 1'b0;
        e.ill   = 1'b0;
        tgt     = pc + imm;
        if (kind == 2'd0) begin
            case (f3)
                3'd0: e.taken = (rs1 == rs2);
                3'd1: e.taken = (rs1 != rs2);
                3'd4: e.taken = (int'(rs1) < int'(rs2));
                3'd5: e.taken = (int'(rs1) >= int'(rs2));
                3'd6: e.taken = (rs1 < rs2);
                3'd7: e.taken = (rs1 >= rs2);
                default: e.ill = 1'b1;
            endcase
        end else if (kind == 2'd1) begin
            e.taken = 1'b1;
        end else if (kind == 2'd2) begin
            e.taken = 1'b1;
            tgt     = (rs1 + imm) & 32'hFFFF_FFFE;
        end else begin
            e.ill = 1'b1;
        end
        e.link   = pc + 32'd4;
        e.target = e.taken ? tgt : pc + 32'd4;
        e.mis    = (e.taken != pt) || (e.taken && tgt != ptgt);
        return e;
    endfunction

    // One cycle of stimulus; pushes the expected result when the request is accepted.
    task automatic step(input bit r, input bit v, input bit k, input bit clr, input bit ordy,
                        input logic [1:0] kind, input logic [2:0] f3,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptgt);
        bit acc;
        @(posedge clk);
        #1;
        m_valid        = m_next;
        rst            = r;
        in_valid       = v;
        kill           = k;
        cnt_clear      = clr;
        out_ready      = ordy;
        in_kind        = kind;
        in_funct3      = f3;
        in_rs1         = rs1;
        in_rs2         = rs2;
        in_pc          = pc;
        in_imm         = imm;
        in_pred_taken  = pt;
        in_pred_target = ptgt;
        #1;
        chk("in_ready", {63'd0, in_ready}, {63'd0, !m_valid || ordy});
        acc = v && (!m_valid || ordy) && !k && !r;
        if (acc) exp_q.push_back(ref_model(kind, f3, rs1, rs2, pc, imm, pt, ptgt));
        m_next = (r || k) ? 1'b0 : acc ? 1'b1 : ordy ? 1'b0 : m_valid;
    endtask

    // Monitor: compares the presented result and counters, then advances the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 64'd1, 64'd0);
                end else begin
                    chk("out_taken", {63'd0, out_taken}, {63'd0, exp_q[0].taken});
                    chk("out_target", {32'd0, out_target}, {32'd0, exp_q[0].target});
                    chk("out_link", {32'd0, out_link}, {32'd0, exp_q[0].link});
                    chk("out_mispredict", {63'd0, out_mispredict}, {63'd0, exp_q[0].mis});
                    chk("out_illegal", {63'd0, out_illegal}, {63'd0, exp_q[0].ill});
                end
            end
            chk("cnt_branches", 64'(cnt_branches), 64'(m_br));
            chk("cnt_mispredicts", 64'(cnt_mispredicts), 64'(m_mp));
            if (rst || cnt_clear) begin
                m_br = 0;
                m_mp = 0;
            end else if (m_valid && out_ready && !kill && exp_q.size() != 0) begin
                if (m_br < SAT) m_br++;
                if (exp_q[0].mis && m_mp < SAT) m_mp++;
            end
            if (m_valid && (rst || kill || out_ready) && exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    initial begin
        logic [1:0]  kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] guess;
        int          sel;
        rst = 1'b1; in_valid = 1'b0; kill = 1'b0; cnt_clear = 1'b0; out_ready = 1'b0;
        in_kind = '0; in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imm = '0;
        in_pred_taken = 1'b0; in_pred_target = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_taken", {63'd0, out_taken}, 64'd0);
        chk("rst_out_target", {32'd0, out_target}, 64'd0);
        chk("rst_out_link", {32'd0, out_link}, 64'd0);
        chk("rst_out_mispredict", {63'd0, out_mispredict}, 64'd0);
        chk("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
        mon_en = 1'b1;

        // Directed cases: BEQ, BLT/BLTU, JALR, illegal funct3 and kind.
        step(0, 1, 0, 0, 1, 2'd0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1, 32'h120);
        step(0, 1, 0, 0, 1, 2'd0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1, 32'h210);
        step(0, 1, 0, 0, 1, 2'd0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 0, 32'h0);
        step(0, 1, 0, 0, 1, 2'd2, 3'd0, 32'h1001, 32'd0, 32'h40, 32'd2, 1, 32'h1000);
        step(0, 1, 0, 0, 1, 2'd0, 3'd2, 32'd1, 32'd2, 32'h300, 32'h8, 1, 32'h308);
        step(0, 1, 0, 0, 1, 2'd3, 3'd0, 32'd1, 32'd2, 32'h400, 32'h8, 0, 32'h0);
        // Backpressure with the request held, then drain back-to-back.
        repeat (3) step(0, 1, 0, 0, 0, 2'd1, 3'd0, 32'd0, 32'd0, 32'h500, 32'h40, 1, 32'h540);
        repeat (3) step(0, 1, 0, 0, 1, 2'd1, 3'd0, 32'd0, 32'd0, 32'h600, 32'h40, 0, 32'h0);
        // Kill while a result is handshaking, then clear alongside a retire.
        step(0, 1, 1, 0, 1, 2'd1, 3'd0, 32'd0, 32'd0, 32'h700, 32'h4, 1, 32'h704);
        step(0, 1, 0, 0, 1, 2'd1, 3'd0, 32'd0, 32'd0, 32'h800, 32'h4, 0, 32'h0);
        step(0, 0, 0, 1, 1, 2'd0, 3'd0, 32'd0, 32'd0, 32'h0, 32'h0, 0, 32'h0);

        for (int i = 0; i < 4000; i++) begin
            sel  = int'($urandom_range(0, 9));
            kind = (sel < 6) ? 2'd0 : (sel < 8) ? 2'd1 : (sel == 8) ? 2'd2 : 2'd3;
            a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc   = $urandom;
            imm  = $urandom;
            guess = ($urandom_range(0, 1) == 0) ? $urandom
                  : (kind == 2'd2) ? ((a + imm) & 32'hFFFF_FFFE) : pc + imm;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0, kind, 3'($urandom_range(0, 7)),
                 a, b, pc, imm, 1'($urandom_range(0, 1)), guess);
        end
        repeat (3) step(0, 0, 0, 0, 1, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 32'd0);
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
